pb_event_scheduler: RTL
=======================

# pb_event_scheduler

Debounce controller and event scheduler for the board push buttons on the 20 MHz domain. It synchronizes N raw button inputs and time-shares one tick prescaler across N small per-button stability counters. Confirmed press edges are queued as pending requests, and a round-robin arbiter serializes them onto a single valid/ready event port. Downstream game/menu logic therefore sees exactly one event per physical press, never a raw level.

## Interface
- `N_PB`, default 4: number of push buttons, range 1..16.
- `TICK_DIV`, default 20000: clk_20mhz cycles per sample tick (1 ms at 20 MHz), minimum 2.
- `STABLE_TICKS`, default 10: consecutive ticks a new level must persist before it is accepted, range 1..255.
- `clk_20mhz`, in, 1: sole clock; all state is updated on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `PB`, in, N_PB: raw asynchronous button levels; 1 = pressed.
- `pb_level`, out, N_PB: debounced stable level per button.
- `evt_valid`, out, 1: a press event is presented.
- `evt_id`, out, max(1, ceil(log2 N_PB)): index of the pressed button.
- `evt_ready`, in, 1: consumer accepts the event.
- `evt_overrun`, out, 1: sticky flag; a press was lost because that button's request was already pending.

## Operation
- **Synchronizer:** a 2-flop synchronizer per `PB` bit produces `pb_sync`. Synchronizer flops reset to 0.
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. `tick` is asserted for one cycle when the count equals TICK_DIV-1.
- **Stability counter (per button i, width 8, updated only on `tick`):**
  - If `pb_sync[i] == pb_level[i]`, the counter clears.
  - Otherwise the counter increments.
  - When the incremented value would equal STABLE_TICKS, `pb_level[i]` toggles and the counter clears.
  - A 0→1 toggle sets press-detect for that tick cycle. A 1→0 toggle produces no event.
- **Pending register (N_PB bits):**
  - A press-detect sets `pend[i]`.
  - If `pend[i]` is already 1 and is not being granted in the same cycle, `evt_overrun` is set. `evt_overrun` is cleared only by reset.
- **Arbiter:** two states.
  - **IDLE:** if any `pend` bit is set, grant the first set bit searching upward from `rr_ptr` with wrap-around. Load `evt_id`, clear that `pend` bit, set `evt_valid`, set `rr_ptr` to the granted index + 1 mod N_PB, and move to PRESENT.
  - **PRESENT:** hold `evt_valid` = 1 and `evt_id` stable. When `evt_ready` = 1, clear `evt_valid` and move to IDLE.
  - No grant is made in the same cycle as an acceptance. Maximum throughput is one event per 2 cycles.
- **Same-cycle set and clear:** if a press-detect and a grant for the same bit occur together, the set wins. The bit stays pending, the granted event is still issued, and no overrun is flagged.
- **Reset values:** `pb_level` = 0, `evt_valid` = 0, `evt_id` = 0, `evt_overrun` = 0, `pend` = 0, `rr_ptr` = 0, prescaler = 0, all stability counters = 0, arbiter in IDLE. Reset mid-operation discards presented and pending events immediately. Buttons held through reset produce a press event after STABLE_TICKS ticks once reset is released.

## Timing
- `PB` change to `pb_sync` change: 2 cycles.
- Acceptance of a level occurs on the STABLE_TICKS-th consecutive tick at which `pb_sync` differs from `pb_level`.
- `pb_level` and `pend` update on the edge ending the tick cycle (T).
- If the arbiter is IDLE, `evt_valid` rises at T+1.
- A glitch shorter than STABLE_TICKS ticks, as seen at the ticks, never changes `pb_level`.
- `evt_valid`/`evt_id` must not change while `evt_valid` = 1 and `evt_ready` = 0.
- `evt_ready` is ignored when `evt_valid` = 0.

## Test plan
All scenarios use N_PB=4, TICK_DIV=4, STABLE_TICKS=3.
1. **Reset:** assert `rst_n` = 0 mid-PRESENT → `evt_valid`, `pb_level`, and `evt_overrun` are all 0 within the same cycle (asynchronous), and no event appears after release with `PB` = 0.
2. **Clean press:** `PB` = 4'b0010 held for 20 cycles with `evt_ready` = 1 → exactly one event with `evt_id` = 1, `pb_level[1]` = 1, `evt_valid` high for exactly 1 cycle. The subsequent release produces no event.
3. **Bounce:** toggle `PB[0]` every 5 cycles for 40 cycles, then hold at 1 → `pb_level[0]` stays 0 during the bounce, then exactly one `evt_id` = 0 event follows.
4. **Round-robin:** `PB` = 4'b1111 pressed simultaneously, `evt_ready` = 1 → events in id order 0, 1, 2, 3, spaced 2 cycles apart. Repeat with `rr_ptr` = 2 → order 2, 3, 0, 1.
5. **Backpressure/overrun:** hold `evt_ready` = 0 with button 3 pending and presenting. Press, release, and re-press button 0 twice → `evt_id` stays stable, `pend[0]` holds one request, and `evt_overrun` = 1.
6. **Same-cycle set and grant:** align a press-detect of button 2 with its grant → one event is issued, `pend[2]` remains 1, and a second event follows with no overrun.

Source files
------------

// File: rtl/pb_event_scheduler_if.sv
// ---------------------------------------------------------------------------
// pb_event_scheduler_if
// Press-event handshake between the push-button scheduler and its consumer.
//   evt_valid : a press event is presented (scheduler -> consumer)
//   evt_id    : index of the pressed button (scheduler -> consumer)
//   evt_ready : consumer accepts the presented event (consumer -> scheduler)
// The master modport is the scheduler side, the slave modport the consumer.
// ---------------------------------------------------------------------------
interface pb_event_scheduler_if #(
  parameter int N_PB = 4
) ();

  localparam int ID_W = (N_PB > 1) ? $clog2(N_PB) : 1;

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/pb_event_scheduler.sv
// ---------------------------------------------------------------------------
// pb_event_scheduler
// Debounces N_PB raw push buttons on the 20 MHz clock and turns each confirmed
// press (0->1 of the debounced level) into exactly one event on a valid/ready
// port. Requests wait in a pending register and are served round-robin.
//
// Ports:
//   clk_20mhz   : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   PB          : raw asynchronous button levels, 1 = pressed
//   pb_level    : debounced stable level per button
//   evt_overrun : sticky, a press was lost because its request was pending
//   evt         : event handshake (master side: evt_valid, evt_id, evt_ready)
// ---------------------------------------------------------------------------
module pb_event_scheduler #(
  parameter int N_PB         = 4,
  parameter int TICK_DIV     = 20000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                 clk_20mhz,
  input  logic                 rst_n,
  input  logic [N_PB-1:0]      PB,
  output logic [N_PB-1:0]      pb_level,
  output logic                 evt_overrun,
  pb_event_scheduler_if.master evt
);

  localparam int ID_W  = (N_PB > 1) ? $clog2(N_PB) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0]       STABLE_MAX = 8'(STABLE_TICKS);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_PB - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // First set request at or above ptr, wrapping; MSB of the result = found.
  function automatic logic [ID_W:0] rr_pick(input logic [N_PB-1:0] req,
                                            input logic [ID_W-1:0] ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = {ID_W{1'b0}};
    for (int k = 0; k < N_PB; k++) begin
      j = (int'(ptr) + k) % N_PB;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  logic [N_PB-1:0]  sync1_r;
  logic [N_PB-1:0]  pb_sync_r;
  logic [PRE_W-1:0] pre_cnt_r;
  logic             tick_s;
  logic [7:0]       cnt_r     [N_PB];
  logic [7:0]       cnt_nxt_s [N_PB];
  logic [N_PB-1:0]  level_r;
  logic [N_PB-1:0]  level_nxt_s;
  logic [N_PB-1:0]  press_s;
  logic [N_PB-1:0]  pend_r;
  logic [N_PB-1:0]  pend_nxt_s;
  logic [N_PB-1:0]  grant_mask_s;
  logic             overrun_r;
  logic             overrun_set_s;
  logic [ID_W:0]    pick_s;
  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  rr_next_s;
  logic             grant_s;
  state_t           state_r;
  state_t           next_state_s;
  logic             evt_valid_r;
  logic [ID_W-1:0]  evt_id_r;

  assign pb_level      = level_r;
  assign evt_overrun   = overrun_r;
  assign evt.evt_valid = evt_valid_r;
  assign evt.evt_id    = evt_id_r;

  // Two-flop synchronizer for the raw button levels.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= {N_PB{1'b0}};
      pb_sync_r <= {N_PB{1'b0}};
    end else begin
      sync1_r   <= PB;
      pb_sync_r <= sync1_r;
    end
  end

  // Shared sample-tick prescaler, wraps at TICK_DIV-1.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else if (pre_cnt_r == PRE_MAX) begin
      pre_cnt_r <= {PRE_W{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1);
    end
  end

  assign tick_s = (pre_cnt_r == PRE_MAX);

  // Per-button stability counters; a level is accepted on the tick where the
  // incremented count would reach STABLE_TICKS. Only 0->1 raises press_s.
  always_comb begin
    level_nxt_s = level_r;
    press_s     = {N_PB{1'b0}};
    for (int i = 0; i < N_PB; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (!tick_s) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else if (pb_sync_r[i] == level_r[i]) begin
        cnt_nxt_s[i] = 8'd0;
      end else if ((cnt_r[i] + 8'd1) == STABLE_MAX) begin
        cnt_nxt_s[i]   = 8'd0;
        level_nxt_s[i] = ~level_r[i];
        press_s[i]     = ~level_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 8'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {N_PB{1'b0}};
      for (int i = 0; i < N_PB; i++) begin
        cnt_r[i] <= 8'd0;
      end
    end else begin
      level_r <= level_nxt_s;
      for (int i = 0; i < N_PB; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign pick_s       = rr_pick(pend_r, rr_ptr_r);
  assign pick_found_s = pick_s[ID_W];
  assign pick_idx_s   = pick_s[ID_W-1:0];
  assign rr_next_s    = (pick_idx_s == LAST_ID) ? {ID_W{1'b0}} : (pick_idx_s + ID_W'(1));

  // Arbiter next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          next_state_s = ST_PRESENT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (evt.evt_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_PRESENT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Arbiter outputs: a grant only ever happens from IDLE, so an acceptance
  // cycle never also grants.
  always_comb begin
    grant_s = 1'b0;
    case (state_r)
      ST_IDLE:    grant_s = pick_found_s;
      ST_PRESENT: grant_s = 1'b0;
      default:    grant_s = 1'b0;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Pending requests: a same-cycle press beats the grant clear, and that case
  // is not an overrun because the granted event is the one being issued.
  always_comb begin
    grant_mask_s  = grant_s ? (N_PB'(1) << pick_idx_s) : {N_PB{1'b0}};
    pend_nxt_s    = (pend_r & ~grant_mask_s) | press_s;
    overrun_set_s = |(press_s & pend_r & ~grant_mask_s);
  end

  // Pending register, sticky overrun and registered event outputs.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= {N_PB{1'b0}};
      overrun_r   <= 1'b0;
      evt_valid_r <= 1'b0;
      evt_id_r    <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
    end else begin
      pend_r      <= pend_nxt_s;
      overrun_r   <= overrun_r | overrun_set_s;
      evt_valid_r <= (next_state_s == ST_PRESENT);
      if (grant_s) begin
        evt_id_r <= pick_idx_s;
        rr_ptr_r <= rr_next_s;
      end
    end
  end

endmodule
